// File: rtl/user_wb_port_regs.sv
// Wishbone-slave register block driving the user I/O pads: ID, scratch, pad out/oeb
// registers and synchronised pad-input readback. One-cycle registered ack.
module user_wb_port_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] CHIP_ID   = 32'h4C42_0001
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] scratch0_q, scratch0_d;
  logic [31:0] scratch1_q, scratch1_d;
  logic [31:0] out_lo_q, out_lo_d;
  logic [5:0]  out_hi_q, out_hi_d;
  logic [31:0] oeb_lo_q, oeb_lo_d;
  logic [5:0]  oeb_hi_q, oeb_hi_d;
  logic [37:0] in_s1_q, in_s2_q;

  logic        sel;
  logic [5:0]  word;
  logic [31:0] cur_word;
  logic [31:0] wmerge;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    return r;
  endfunction

  assign sel  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign word = wbs_adr_i[7:2];

  // Current contents of the addressed word; doubles as the base for byte-lane merging.
  always_comb begin
    cur_word = 32'd0;
    case (word)
      6'd0: cur_word = CHIP_ID;
      6'd1: cur_word = scratch0_q;
      6'd2: cur_word = scratch1_q;
      6'd3: cur_word = out_lo_q;
      6'd4: cur_word = {26'd0, out_hi_q};
      6'd5: cur_word = oeb_lo_q;
      6'd6: cur_word = {26'd0, oeb_hi_q};
      6'd7: cur_word = in_s2_q[31:0];
      6'd8: cur_word = {26'd0, in_s2_q[37:32]};
      default: cur_word = 32'd0;
    endcase
  end

  assign wmerge = merge_bytes(cur_word, wbs_dat_i, wbs_sel_i);

  always_comb begin
    ack_d      = sel;
    dat_d      = 32'd0;
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    out_lo_d   = out_lo_q;
    out_hi_d   = out_hi_q;
    oeb_lo_d   = oeb_lo_q;
    oeb_hi_d   = oeb_hi_q;
    if (sel) begin
      if (wbs_we_i) begin
        case (word)
          6'd1: scratch0_d = wmerge;
          6'd2: scratch1_d = wmerge;
          6'd3: out_lo_d   = wmerge;
          6'd4: out_hi_d   = wmerge[5:0];
          6'd5: oeb_lo_d   = wmerge;
          6'd6: oeb_hi_d   = wmerge[5:0];
          default: ;
        endcase
      end else begin
        dat_d = cur_word;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      scratch0_q <= 32'd0;
      scratch1_q <= 32'd0;
      out_lo_q   <= 32'd0;
      out_hi_q   <= 6'd0;
      oeb_lo_q   <= 32'hFFFF_FFFF;
      oeb_hi_q   <= 6'h3F;
      in_s1_q    <= 38'd0;
      in_s2_q    <= 38'd0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      out_lo_q   <= out_lo_d;
      out_hi_q   <= out_hi_d;
      oeb_lo_q   <= oeb_lo_d;
      oeb_hi_q   <= oeb_hi_d;
      in_s1_q    <= io_in;
      in_s2_q    <= in_s1_q;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = {out_hi_q, out_lo_q};
  assign io_oeb    = {oeb_hi_q, oeb_lo_q};

endmodule

// File: tb/tb_user_wb_port_regs.sv
// Directed bench for user_wb_port_regs: reset, signature, byte lanes, decode,
// pad-input sync and reset during an access.
module tb_user_wb_port_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] CID  = 32'h4C42_0001;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [37:0] io_in = 38'd0;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  int checks = 0;
  int errors = 0;
  logic        ack_after;
  logic [31:0] rd;

  user_wb_port_regs dut (
    .clock     (clock),
    .resetb    (resetb),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: strobe from a falling edge, wait up to 16 edges for ack, then one idle edge.
  task automatic wb_xfer(input string tag, input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d,
                         input logic exp_ack, output logic [31:0] rdat);
    int n;
    logic got;
    @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
    wbs_sel_i = s; wbs_adr_i = a; wbs_dat_i = d;
    got = 1'b0; n = 0; rdat = 32'd0;
    while (!got && n < 16) begin
      @(posedge clock); #1;
      n++;
      if (wbs_ack_o === 1'b1) begin
        got = 1'b1;
        rdat = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (exp_ack) check({tag, " ack latency"}, 64'(n), 64'd1);
    else         check({tag, " no ack"}, {63'd0, got}, 64'd0);
    @(posedge clock); #1;
    ack_after = wbs_ack_o;
  endtask

  initial begin
    // Reset asserted mid-cycle
    repeat (2) @(posedge clock);
    #2 resetb = 1'b0;
    #1;
    check("rst ack", {63'd0, wbs_ack_o}, 64'd0);
    check("rst dat", {32'd0, wbs_dat_o}, 64'd0);
    check("rst io_out", {26'd0, io_out}, 64'd0);
    check("rst io_oeb", {26'd0, io_oeb}, 64'h3F_FFFF_FFFF);
    #1 resetb = 1'b1;

    wb_xfer("id rd", BASE + 32'h00, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("id data", {32'd0, rd}, {32'd0, CID});
    check("ack one cycle", {63'd0, ack_after}, 64'd0);

    // Signature
    wb_xfer("oeb_lo wr", BASE + 32'h14, 1'b1, 4'hF, 32'h0000_FFFF, 1'b1, rd);
    wb_xfer("out_lo wr0", BASE + 32'h0C, 1'b1, 4'hF, 32'hAB60_0000, 1'b1, rd);
    check("sig start", {48'd0, io_out[31:16]}, 64'hAB60);
    check("oeb drive", {48'd0, io_oeb[31:16]}, 64'h0);
    check("oeb low half", {48'd0, io_oeb[15:0]}, 64'hFFFF);
    wb_xfer("out_lo wr1", BASE + 32'h0C, 1'b1, 4'hF, 32'hAB61_0000, 1'b1, rd);
    check("sig pass", {48'd0, io_out[31:16]}, 64'hAB61);

    // Byte lanes
    wb_xfer("scr0 wr", BASE + 32'h04, 1'b1, 4'hF, 32'h1234_5678, 1'b1, rd);
    wb_xfer("scr0 wr lanes", BASE + 32'h04, 1'b1, 4'b0101, 32'hAAAA_AAAA, 1'b1, rd);
    wb_xfer("scr0 rd", BASE + 32'h04, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("scr0 data", {32'd0, rd}, 64'h12AA_56AA);
    wb_xfer("scr1 wr", BASE + 32'h08, 1'b1, 4'b1000, 32'h5A00_0000, 1'b1, rd);
    wb_xfer("scr1 rd", BASE + 32'h08, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("scr1 data", {32'd0, rd}, 64'h5A00_0000);

    // High pad bits: only [5:0] implemented
    wb_xfer("out_hi wr", BASE + 32'h10, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, rd);
    check("out_hi pads", {58'd0, io_out[37:32]}, 64'h3F);
    wb_xfer("out_hi rd", BASE + 32'h10, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("out_hi data", {32'd0, rd}, 64'h3F);
    wb_xfer("oeb_hi wr", BASE + 32'h18, 1'b1, 4'h1, 32'h0000_0015, 1'b1, rd);
    check("oeb_hi pads", {58'd0, io_oeb[37:32]}, 64'h15);

    // Decode
    wb_xfer("oow wr", 32'h3000_010C, 1'b1, 4'hF, 32'h0000_0000, 1'b0, rd);
    check("oow no change", {32'd0, io_out[31:0]}, 64'hAB61_0000);
    wb_xfer("hole rd", BASE + 32'h40, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("hole data", {32'd0, rd}, 64'd0);
    wb_xfer("id wr", BASE + 32'h00, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, rd);
    wb_xfer("id rd2", BASE + 32'h00, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("id ro", {32'd0, rd}, {32'd0, CID});

    // Input path
    @(negedge clock);
    io_in = 38'h25_DEAD_BEEF;
    repeat (2) @(posedge clock);
    wb_xfer("in_lo rd", BASE + 32'h1C, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("in_lo data", {32'd0, rd}, 64'hDEAD_BEEF);
    wb_xfer("in_hi rd", BASE + 32'h20, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("in_hi data", {32'd0, rd}, 64'h25);
    // Pad change coincident with a read returns the previously held value
    @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE + 32'h1C; io_in = 38'h0A_1234_5678;
    @(posedge clock); #1;
    check("in_lo race ack", {63'd0, wbs_ack_o}, 64'd1);
    check("in_lo race data", {32'd0, wbs_dat_o}, 64'hDEAD_BEEF);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clock); #1;

    // Reset while a write to OUT_HI is strobed
    @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'h10; wbs_dat_i = 32'h0000_002A;
    #2 resetb = 1'b0;
    @(posedge clock); #1;
    check("abort ack", {63'd0, wbs_ack_o}, 64'd0);
    check("abort out_hi", {58'd0, io_out[37:32]}, 64'h0);
    @(negedge clock);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    #1 resetb = 1'b1;
    wb_xfer("out_hi rd2", BASE + 32'h10, 1'b0, 4'hF, 32'd0, 1'b1, rd);
    check("out_hi after abort", {32'd0, rd}, 64'h0);

    // Continuously held strobe: ack every other edge
    @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check($sformatf("held ack %0d", i), {63'd0, wbs_ack_o}, (i % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("held dat %0d", i), {32'd0, wbs_dat_o}, (i % 2 == 0) ? {32'd0, CID} : 64'd0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_wb_port_regs.md
Name: user_wb_port_regs

Overview:
- Wishbone-slave register block in the user-project area, reached from the management SoC's Wishbone master window.
- Firmware fetched from the SPI flash programs it to drive the user I/O pads.
- Bring-up tests use its pad outputs as status signatures: io_out[31:16] reads 16'hAB60 when the test starts and 16'hAB61 when it passes.
- Provides an ID register, scratch registers, pad output and output-enable registers, and synchronised pad-input readback.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone window base; only bits [31:8] are compared.
- CHIP_ID, 32'h4C42_0001, value returned by the ID register.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- resetb  input  1  asynchronous, active-low reset.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  1 = write.
- wbs_sel_i  input  4  byte lane enables.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_ack_o  output  1  transfer acknowledge.
- wbs_dat_o  output  32  read data.
- io_in  input  38  pad inputs.
- io_out  output  38  pad output values.
- io_oeb  output  38  pad output enables, active-low (0 = drive).

Behaviour:
- Select condition: sel = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & !wbs_ack_o.
- Acknowledge: on sel, wbs_ack_o = 1 on the next rising edge, for exactly one cycle.
  - Minimum 2 cycles per access; back-to-back strobes are served every other cycle.
- Out-of-window addresses: never acknowledged; no state change.
- Write: on the select edge, each byte lane i with wbs_sel_i[i]=1 updates byte i of the addressed register. Other lanes are unchanged.
- Read: wbs_dat_o is registered and valid in the ack cycle. It is 0 in every other cycle.
- Register map (offset = wbs_adr_i[7:0], word-aligned; wbs_adr_i[1:0] ignored):
  - 0x00 ID, read-only, CHIP_ID.
  - 0x04 SCRATCH0, RW 32, reset 0.
  - 0x08 SCRATCH1, RW 32, reset 0.
  - 0x0C OUT_LO, RW 32, drives io_out[31:0], reset 0.
  - 0x10 OUT_HI, RW [5:0], drives io_out[37:32]; bits [31:6] read 0; reset 0.
  - 0x14 OEB_LO, RW 32, drives io_oeb[31:0], reset 32'hFFFF_FFFF.
  - 0x18 OEB_HI, RW [5:0], drives io_oeb[37:32], reset 6'h3F.
  - 0x1C IN_LO, read-only, synchronised io_in[31:0].
  - 0x20 IN_HI, read-only, synchronised io_in[37:32] in bits [5:0], upper bits 0.
  - Any other offset in the window: acknowledged, reads 0, writes ignored.
- Pad outputs: io_out and io_oeb come directly from register flops. A write becomes visible on the pads in the same edge as the ack.
- Pad inputs: io_in passes through a 2-flop synchroniser. A stable pad change is readable 2 edges later.
- Reset (resetb low): asynchronously forces all registers to their reset values, wbs_ack_o=0 and wbs_dat_o=0.
  - Reset during a pending access aborts it: no ack, no write.
  - The first select is possible on the first rising edge after resetb deasserts.
- Writes to read-only registers: acknowledged, ignored.
- Simultaneous pad-input change and IN register read: returns the synchroniser value held before that edge.

Test Plan:
- Reset check:
  - Assert resetb=0 mid-cycle. All outputs go low immediately, except io_oeb = 38'h3F_FFFF_FFFF.
  - Read 0x00 -> 32'h4C42_0001; ack exactly 1 cycle after strobe.
- Signature:
  - Write OEB_LO = 32'h0000_FFFF, then OUT_LO = 32'hAB60_0000 -> io_out[31:16] = 16'hAB60 and io_oeb[31:16] = 0.
  - Then write OUT_LO = 32'hAB61_0000 -> io_out[31:16] = 16'hAB61.
- Byte lanes:
  - Write SCRATCH0 = 32'h1234_5678 (sel=4'hF), then 32'hAAAA_AAAA with sel=4'b0101.
  - Readback -> 32'h12AA_56AA.
- Decode:
  - Access 0x3000_0100 -> no ack for 16 cycles, no state change.
  - Access offset 0x40 -> ack with data 0.
  - Write ID -> readback still CHIP_ID.
- Input path: drive io_in = 38'h25_DEAD_BEEF -> IN_LO reads 32'hDEAD_BEEF and IN_HI reads 32'h25, from the 2nd edge onward.
- Reset mid-operation:
  - Assert resetb while a write to OUT_HI is strobed -> no ack, OUT_HI stays 0.
  - After release, a strobe held continuously is acked every other cycle.
